// File: rtl/weight_pkg.sv
// Shared definitions for the weight loader: default sizes and the stream FSM state encoding.
package weight_pkg;

  localparam int N_DEF         = 8;
  localparam int WEIGHT_BW_DEF = 8;
  localparam int CNT_W_DEF     = $clog2(N_DEF * N_DEF);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CHECK,
    WAIT_COMMIT,
    COMMIT
  } state_e;

endpackage

// File: rtl/weight_stream_fsm.sv
// Stream-side control for the weight loader: state, beat counter, handshake and strobe decode.
// The CHECK state is only reachable when WEIGHT_LOADER_CHKSUM_EN is defined.
module weight_stream_fsm
  import weight_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int CNT_W = $clog2(N * N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  input  logic             flush,
  input  logic             commit_ok,
`ifdef WEIGHT_LOADER_CHKSUM_EN
  input  logic             chk_match,
`endif
  output logic             s_ready,
  output logic             wr_en,
  output logic [CNT_W-1:0] wr_idx,
  output logic             busy,
  output logic             weight_reload,
  output logic             load_done,
  output logic             load_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ready_st;
  logic             accept;
  logic             last_beat;

  // Readiness is masked by reset so nothing looks acceptable while rstn is low.
  assign s_ready   = rstn & ready_st;
  assign accept    = s_valid & s_ready;
  assign last_beat = (cnt_q == CNT_W'(N * N - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    ready_st = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_st = 1'b1;
        if (accept) begin
          wr_en   = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        ready_st = 1'b1;
        if (accept) begin
          wr_en = 1'b1;
          if (last_beat) begin
            cnt_d = '0;
`ifdef WEIGHT_LOADER_CHKSUM_EN
            state_d = CHECK;
`else
            state_d = WAIT_COMMIT;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef WEIGHT_LOADER_CHKSUM_EN
      CHECK: begin
        ready_st = 1'b1;
        if (accept) begin
          if (chk_match) begin
            state_d = WAIT_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      WAIT_COMMIT: begin
        if (commit_ok) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort overrides everything; a beat offered alongside it is consumed and dropped.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      wr_en   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign wr_idx        = cnt_q;
  assign busy          = (state_q != IDLE);
  assign weight_reload = (state_q == COMMIT);
  assign load_done     = (state_q == COMMIT);
  assign load_err      = err_q;

endmodule

// File: rtl/weight_loader.sv
// Assembles an N x N signed weight matrix from a byte stream into a shadow buffer and strobes it
// into the PE weight registers. Optional trailing XOR checksum beat: WEIGHT_LOADER_CHKSUM_EN.
module weight_loader
  import weight_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int WEIGHT_BW = WEIGHT_BW_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [WEIGHT_BW-1:0] s_data,
  input  logic                        flush,
  input  logic                        commit_ok,
  output logic [N*N*WEIGHT_BW-1:0]    weight_bus,
  output logic                        weight_reload,
  output logic                        busy,
  output logic                        load_done,
  output logic                        load_err
);

  localparam int CNT_W = $clog2(N * N);

  logic                     wr_en;
  logic [CNT_W-1:0]         wr_idx;
  logic [N*N*WEIGHT_BW-1:0] shadow_q, shadow_d;

`ifdef WEIGHT_LOADER_CHKSUM_EN
  logic [WEIGHT_BW-1:0] xor_q, xor_d;
  logic                 chk_match;

  // Element 0 always opens a matrix, so restarting the XOR there is the same as clearing in IDLE.
  always_comb begin
    xor_d = xor_q;
    if (wr_en) xor_d = (wr_idx == '0) ? s_data : (xor_q ^ s_data);
  end

  assign chk_match = (s_data == xor_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) xor_q <= '0;
    else       xor_q <= xor_d;
  end
`endif

  weight_stream_fsm #(.N(N)) u_fsm (
    .clk           (clk),
    .rstn          (rstn),
    .s_valid       (s_valid),
    .flush         (flush),
    .commit_ok     (commit_ok),
`ifdef WEIGHT_LOADER_CHKSUM_EN
    .chk_match     (chk_match),
`endif
    .s_ready       (s_ready),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .busy          (busy),
    .weight_reload (weight_reload),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) shadow_d[int'(wr_idx) * WEIGHT_BW +: WEIGHT_BW] = s_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  // The bus is the shadow itself; downstream only samples it on the reload strobe.
  assign weight_bus = shadow_q;

endmodule
